regex_stream_ctx: RTL and testbench

// Parametrised per-stream context manager for one DFA regex engine in the DPI datapath. Saves and restores

---
 rtl/regex_ctx_pkg.sv | 23 ++
 rtl/regex_ctx_ram.sv | 35 +++
 rtl/regex_stream_ctx.sv | 141 ++++++++++++++
 tb/tb_regex_stream_ctx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regex_ctx_pkg.sv
// Shared types, default widths and helpers for the per-stream regex context manager.
package regex_ctx_pkg;

  localparam int unsigned DEF_NUM_STREAMS = 64;
  localparam int unsigned DEF_SID_W       = 6;
  localparam int unsigned DEF_STATE_W     = 11;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_STATE_INIT  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    COMMIT = 2'd3
  } ctx_state_e;

  // Width-agnostic saturating increment; callers zero-extend to 64 bits and truncate back.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic inc,
                                          input logic [63:0] max_val);
    return (inc && (val != max_val)) ? val + 64'd1 : val;
  endfunction

endpackage

// File: rtl/regex_ctx_ram.sv
// Per-stream {engine state, match count} array: one write port, two synchronous read ports.
module regex_ctx_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned SW    = 11,
  parameter int unsigned CW    = 16
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [SW+CW-1:0] wdata_i,
  input  logic             fsm_re_i,
  input  logic [AW-1:0]    fsm_raddr_i,
  output logic [SW+CW-1:0] fsm_rdata_o,
  input  logic             host_re_i,
  input  logic [AW-1:0]    host_raddr_i,
  output logic [CW-1:0]    host_cnt_o
);

  logic [SW+CW-1:0] mem_q [DEPTH];
  logic [SW+CW-1:0] fsm_rdata_q;
  logic [CW-1:0]    host_cnt_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (fsm_re_i) fsm_rdata_q <= mem_q[fsm_raddr_i];
    // Host port is write-first so a read colliding with a commit sees the new count.
    if (host_re_i) host_cnt_q <= (we_i && (waddr_i == host_raddr_i)) ? wdata_i[CW-1:0]
                                                                    : mem_q[host_raddr_i][CW-1:0];
  end

  assign fsm_rdata_o = fsm_rdata_q;
  assign host_cnt_o  = host_cnt_q;

endmodule

// File: rtl/regex_stream_ctx.sv
// Saves/restores DFA engine state per stream, flags a match per packet and keeps
// a saturating per-stream match count readable by the host.
module regex_stream_ctx
  import regex_ctx_pkg::*;
#(
  parameter int unsigned NUM_STREAMS = DEF_NUM_STREAMS,
  parameter int unsigned SID_W       = DEF_SID_W,
  parameter int unsigned STATE_W     = DEF_STATE_W,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned STATE_INIT  = DEF_STATE_INIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pkt_start,
  input  logic [SID_W-1:0]   pkt_sid,
  input  logic               pkt_enable,
  input  logic               eop,
  input  logic               clr_req,
  input  logic [SID_W-1:0]   clr_sid,
  output logic               start_rdy,
  output logic [STATE_W-1:0] eng_state_in,
  output logic               eng_state_ld,
  input  logic [STATE_W-1:0] eng_state_out,
  input  logic               eng_accept,
  output logic               fired,
  input  logic               rd_req,
  input  logic [SID_W-1:0]   rd_sid,
  output logic [CNT_W-1:0]   rd_count,
  output logic               rd_vld,
  output logic               protocol_err
);

  localparam int unsigned        MEM_W   = STATE_W + CNT_W;
  localparam logic [STATE_W-1:0] INIT_S  = STATE_W'(STATE_INIT);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  ctx_state_e             state_q;
  logic [SID_W-1:0]       sid_q;
  logic                   en_q;
  logic                   fired_q;
  logic                   ld_q;
  logic                   ld_vld_q;
  logic                   perr_q;
  logic                   rd_vld_q;
  logic                   rd_hit_q;
  logic [NUM_STREAMS-1:0] valid_q;
  logic [NUM_STREAMS-1:0] valid_d;

  logic                   start_acc;
  logic                   commit_we;
  logic [MEM_W-1:0]       fsm_rdata;
  logic [CNT_W-1:0]       host_cnt;
  logic [CNT_W-1:0]       cnt_old;
  logic [CNT_W-1:0]       cnt_new;
  logic [MEM_W-1:0]       wdata;

  assign start_acc = pkt_start && (state_q == IDLE);
  assign commit_we = eop && (state_q == RUN) && en_q;

  // A context cleared mid-packet commits as if it started from a zero count.
  assign cnt_old = valid_q[sid_q] ? fsm_rdata[CNT_W-1:0] : '0;
  assign cnt_new = CNT_W'(sat_inc(64'(cnt_old), fired_q | eng_accept, 64'(CNT_MAX)));
  assign wdata   = {eng_state_out, cnt_new};

  regex_ctx_ram #(
    .DEPTH (NUM_STREAMS),
    .AW    (SID_W),
    .SW    (STATE_W),
    .CW    (CNT_W)
  ) u_ram (
    .clk          (clk),
    .we_i         (commit_we),
    .waddr_i      (sid_q),
    .wdata_i      (wdata),
    .fsm_re_i     (start_acc),
    .fsm_raddr_i  (pkt_sid),
    .fsm_rdata_o  (fsm_rdata),
    .host_re_i    (rd_req),
    .host_raddr_i (rd_sid),
    .host_cnt_o   (host_cnt)
  );

  // Clear is applied after the commit so it wins a same-cycle collision.
  always_comb begin
    valid_d = valid_q;
    if (commit_we) valid_d[sid_q] = 1'b1;
    if (clr_req)   valid_d[clr_sid] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sid_q    <= '0;
      en_q     <= 1'b0;
      fired_q  <= 1'b0;
      ld_q     <= 1'b0;
      ld_vld_q <= 1'b0;
      perr_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_hit_q <= 1'b0;
      valid_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      ld_q     <= start_acc;
      rd_vld_q <= rd_req;
      if (rd_req) rd_hit_q <= valid_d[rd_sid];
      if ((pkt_start && (state_q != IDLE)) || (eop && (state_q != RUN))) perr_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pkt_start) begin
            sid_q    <= pkt_sid;
            en_q     <= pkt_enable;
            fired_q  <= 1'b0;
            ld_vld_q <= valid_q[pkt_sid];
            state_q  <= LOAD;
          end
        end
        LOAD: state_q <= RUN;
        RUN: begin
          if (eng_accept) fired_q <= 1'b1;
          if (eop) begin
            if (!en_q) fired_q <= 1'b0;
            state_q <= COMMIT;
          end
        end
        COMMIT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Load value is latched at start, so a clear during LOAD cannot change what the engine sees.
  assign eng_state_in = ld_vld_q ? fsm_rdata[MEM_W-1 -: STATE_W] : INIT_S;
  assign eng_state_ld = ld_q;
  assign start_rdy    = (state_q == IDLE);
  assign fired        = fired_q;
  assign rd_vld       = rd_vld_q;
  assign rd_count     = rd_hit_q ? host_cnt : '0;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_regex_stream_ctx.sv
// Directed bench for regex_stream_ctx; a second instance with a 2-bit counter exercises saturation.
module tb_regex_stream_ctx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_start = 1'b0;
  logic [5:0]  pkt_sid = '0;
  logic        pkt_enable = 1'b0;
  logic        eop = 1'b0;
  logic        clr_req = 1'b0;
  logic [5:0]  clr_sid = '0;
  logic [10:0] eng_state_out = '0;
  logic        eng_accept = 1'b0;
  logic        rd_req = 1'b0;
  logic [5:0]  rd_sid = '0;

  logic        start_rdy, eng_state_ld, fired, rd_vld, protocol_err;
  logic [10:0] eng_state_in;
  logic [15:0] rd_count;

  logic        s_start_rdy, s_eng_state_ld, s_fired, s_rd_vld, s_protocol_err;
  logic [10:0] s_eng_state_in;
  logic [1:0]  s_rd_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regex_stream_ctx dut (
    .clk(clk), .rst(rst), .pkt_start(pkt_start), .pkt_sid(pkt_sid), .pkt_enable(pkt_enable),
    .eop(eop), .clr_req(clr_req), .clr_sid(clr_sid), .start_rdy(start_rdy),
    .eng_state_in(eng_state_in), .eng_state_ld(eng_state_ld), .eng_state_out(eng_state_out),
    .eng_accept(eng_accept), .fired(fired), .rd_req(rd_req), .rd_sid(rd_sid),
    .rd_count(rd_count), .rd_vld(rd_vld), .protocol_err(protocol_err)
  );

  regex_stream_ctx #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pkt_start(pkt_start), .pkt_sid(pkt_sid), .pkt_enable(pkt_enable),
    .eop(eop), .clr_req(clr_req), .clr_sid(clr_sid), .start_rdy(s_start_rdy),
    .eng_state_in(s_eng_state_in), .eng_state_ld(s_eng_state_ld), .eng_state_out(eng_state_out),
    .eng_accept(eng_accept), .fired(s_fired), .rd_req(rd_req), .rd_sid(rd_sid),
    .rd_count(s_rd_count), .rd_vld(s_rd_vld), .protocol_err(s_protocol_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues pkt_start in the current IDLE cycle; returns in the first RUN cycle.
  task automatic pkt_begin(input string tag, input logic [5:0] sid, input logic en,
                           input logic [10:0] exp_state);
    chk({tag, "_rdy"}, start_rdy, 1);
    pkt_start = 1'b1; pkt_sid = sid; pkt_enable = en;
    tick();
    pkt_start = 1'b0;
    chk({tag, "_ld"}, eng_state_ld, 1);
    chk({tag, "_sin"}, eng_state_in, exp_state);
    chk({tag, "_fclr"}, fired, 0);
    tick();
    chk({tag, "_ld1"}, eng_state_ld, 0);
  endtask

  // eop in the current RUN cycle; returns in the following IDLE cycle.
  task automatic pkt_end(input string tag, input logic [10:0] st, input logic acc,
                         input logic exp_fired);
    eop = 1'b1; eng_state_out = st; eng_accept = acc;
    tick();
    eop = 1'b0; eng_accept = 1'b0;
    chk({tag, "_cmt_rdy"}, start_rdy, 0);
    chk({tag, "_fired"}, fired, exp_fired);
    tick();
    chk({tag, "_rdy2"}, start_rdy, 1);
  endtask

  task automatic rd(input string tag, input logic [5:0] sid, input logic [15:0] exp);
    rd_req = 1'b1; rd_sid = sid;
    tick();
    rd_req = 1'b0;
    chk({tag, "_vld"}, rd_vld, 1);
    chk({tag, "_cnt"}, rd_count, exp);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_rdy", start_rdy, 1);
    chk("rst_ld", eng_state_ld, 0);
    chk("rst_fired", fired, 0);
    chk("rst_rdvld", rd_vld, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_sin", eng_state_in, 0);
    chk("rst_cnt", rd_count, 0);

    // fresh stream 5 with a mid-packet match
    pkt_begin("s5a", 6'd5, 1'b1, 11'h000);
    eng_accept = 1'b0; tick();
    eng_accept = 1'b1; tick(); eng_accept = 1'b0;
    chk("s5a_run_fired", fired, 1);
    pkt_end("s5a", 11'h123, 1'b0, 1'b1);
    rd("s5a_rd", 6'd5, 16'd1);
    tick();
    chk("s5a_rdvld_pulse", rd_vld, 0);

    // second packet on stream 5, no match
    pkt_begin("s5b", 6'd5, 1'b1, 11'h123);
    pkt_end("s5b", 11'h02A, 1'b0, 1'b0);
    rd("s5b_rd", 6'd5, 16'd1);

    // interleaved streams 3 and 9
    pkt_begin("s3a", 6'd3, 1'b1, 11'h000);
    eng_accept = 1'b1; tick(); eng_accept = 1'b0;
    pkt_end("s3a", 11'h333, 1'b0, 1'b1);
    pkt_begin("s9a", 6'd9, 1'b1, 11'h000);
    pkt_end("s9a", 11'h099, 1'b0, 1'b0);
    pkt_begin("s3b", 6'd3, 1'b1, 11'h333);
    pkt_end("s3b", 11'h334, 1'b1, 1'b1);
    pkt_begin("s9b", 6'd9, 1'b1, 11'h099);
    eop = 1'b1; eng_state_out = 11'h09A; eng_accept = 1'b1; rd_req = 1'b1; rd_sid = 6'd9;
    tick();
    eop = 1'b0; eng_accept = 1'b0; rd_req = 1'b0;
    chk("byp_vld", rd_vld, 1);
    chk("byp_cnt", rd_count, 1);
    chk("byp_fired", fired, 1);
    tick();
    chk("s9b_rdy", start_rdy, 1);
    rd("s3_rd", 6'd3, 16'd2);
    rd("s9_rd", 6'd9, 16'd1);

    // disabled packet leaves context untouched
    pkt_begin("s5dis", 6'd5, 1'b0, 11'h02A);
    eng_accept = 1'b1; tick(); eng_accept = 1'b0;
    chk("s5dis_run_fired", fired, 1);
    pkt_end("s5dis", 11'h3FF, 1'b1, 1'b0);
    pkt_begin("s5c", 6'd5, 1'b1, 11'h02A);
    pkt_end("s5c", 11'h02A, 1'b0, 1'b0);
    rd("s5c_rd", 6'd5, 16'd1);

    // saturation on the 2-bit instance; wide instance keeps counting
    for (int unsigned i = 0; i < 4; i++) begin
      pkt_begin("s7", 6'd7, 1'b1, (i == 0) ? 11'h000 : 11'h055);
      pkt_end("s7", 11'h055, 1'b1, 1'b1);
      if (i == 2) begin
        rd("s7_rd3", 6'd7, 16'd3);
        chk("s7_sat3", s_rd_count, 3);
      end
    end
    rd("s7_rd4", 6'd7, 16'd4);
    chk("s7_sat4", s_rd_count, 3);
    clr_req = 1'b1; clr_sid = 6'd7;
    tick();
    clr_req = 1'b0;
    rd("s7_clr_rd", 6'd7, 16'd0);
    chk("s7_clr_sat", s_rd_count, 0);
    pkt_begin("s7c", 6'd7, 1'b1, 11'h000);
    pkt_end("s7c", 11'h066, 1'b1, 1'b1);
    rd("s7c_rd", 6'd7, 16'd1);

    // clear collides with commit of the same stream: clear wins
    pkt_begin("s9c", 6'd9, 1'b1, 11'h09A);
    clr_req = 1'b1; clr_sid = 6'd9;
    pkt_end("s9c", 11'h0AA, 1'b0, 1'b0);
    clr_req = 1'b0;
    rd("s9c_rd", 6'd9, 16'd0);
    pkt_begin("s9d", 6'd9, 1'b1, 11'h000);
    pkt_end("s9d", 11'h0AB, 1'b0, 1'b0);
    rd("s9d_rd", 6'd9, 16'd0);

    // eop outside RUN
    chk("perr_pre", protocol_err, 0);
    eop = 1'b1; tick(); eop = 1'b0;
    chk("perr_eop", protocol_err, 1);
    chk("perr_eop_rdy", start_rdy, 1);

    // reset mid-RUN
    pkt_begin("s3r", 6'd3, 1'b1, 11'h334);
    eng_accept = 1'b1; tick(); eng_accept = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstrun_rdy", start_rdy, 1);
    chk("rstrun_perr", protocol_err, 0);
    chk("rstrun_fired", fired, 0);
    rd("rstrun_rd3", 6'd3, 16'd0);
    rd("rstrun_rd5", 6'd5, 16'd0);

    // pkt_start during RUN is ignored
    pkt_begin("s3p", 6'd3, 1'b1, 11'h000);
    pkt_start = 1'b1; pkt_sid = 6'd9; tick(); pkt_start = 1'b0;
    chk("perr_start", protocol_err, 1);
    chk("perr_start_ld", eng_state_ld, 0);
    chk("perr_start_rdy", start_rdy, 0);
    pkt_end("s3p", 11'h0C3, 1'b0, 1'b0);
    chk("perr_sticky", protocol_err, 1);
    pkt_begin("s3q", 6'd3, 1'b1, 11'h0C3);
    pkt_end("s3q", 11'h0C4, 1'b0, 1'b0);
    rd("s3q_rd", 6'd3, 16'd0);
    rd("s9q_rd", 6'd9, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
